generation_timer: RTL and testbench
===================================

# generation_timer

- Loadable down-counter with borrow output and a start/stop/pause state machine.
- Counterpart to the free-running up-counter: the up-counter's carry feeds this block's `tick`.
- The block counts down a programmed number of ticks, then pulses `borrow` to advance the Conway simulation by one generation.
- Supports one-shot and auto-reload (periodic stepping) modes.

## Interface

Parameters:
- `WIDTH`, default 8: counter and load width.
- `DEFAULT_LOAD`, default 20: reload value after reset; must be nonzero.

Ports (reset `resetn`, synchronous, active-low; clock `clk`):
- `clk`  in  1  clock.
- `resetn`  in  1  synchronous active-low reset.
- `tick`  in  1  count strobe; one decrement per cycle it is high in RUN.
- `load_valid`  in  1  load request.
- `load_ready`  out  1  load can be accepted this cycle.
- `load_value`  in  WIDTH  new reload value.
- `start`  in  1  level-sampled; start or resume.
- `stop`  in  1  level-sampled; pause, or abort from PAUSED.
- `auto_reload`  in  1  sampled at expiry; 1 means periodic, 0 means one-shot.
- `count`  out  WIDTH  current remaining ticks (registered).
- `borrow`  out  1  one-cycle expiry pulse (registered).
- `busy`  out  1  high in RUN or PAUSED (registered).

## Operation

States: IDLE, RUN, PAUSED, EXPIRED.

Reset (and power-up initial values):
- State IDLE.
- `count` = `reload` = `DEFAULT_LOAD`.
- `borrow` = 0, `busy` = 0.

Load:
- `load_ready` = 1 in IDLE/EXPIRED, 0 in RUN/PAUSED.
- A load is accepted when `load_valid && load_ready`.
- On acceptance, `reload` and `count` take `load_value`. A `load_value` of 0 is stored as 1.

Transitions:
- IDLE/EXPIRED + `start` → RUN, with `count` = `reload`.
  - If a load is accepted in the same cycle, the new value is used.
- RUN + `tick`, `count` > 1 → `count` − 1.
- RUN + `tick`, `count` == 1 (terminal) → `borrow` pulses.
  - `auto_reload` = 1: `count` = `reload`, stay RUN.
  - `auto_reload` = 0: `count` = 0, go EXPIRED.
- RUN + `stop` → PAUSED. A `tick` in the same cycle is discarded.
- PAUSED + `start` → RUN, `count` unchanged; ticks are ignored while PAUSED.
- PAUSED + `stop` → IDLE, `count` = `reload`.

Priority and ignored inputs:
- `stop` beats `start` in every state.
- `stop` in IDLE/EXPIRED is ignored.
- `start` in RUN is ignored.

Arithmetic:
- `count` never wraps below 0.
- The `count` == 1 terminal test is exact-width.
- Period in auto-reload mode is exactly `reload` ticks.

Reset mid-operation: returns to the reset values regardless of state. Any pending `borrow` is cleared.

## Timing

- All outputs are registered; no combinational path from inputs to outputs except `load_ready`, which decodes the state register only.
- `borrow` is high for exactly the one cycle after the edge that sampled the terminal tick. In that cycle `count` already shows `reload` (auto) or 0 (one-shot).
- A `start` sampled at edge N means `busy` = 1 and `count` = `reload` are visible after edge N.
- The first decrement happens on a tick sampled at edge N+1 or later.
- A load accepted at edge N is visible on `count` after edge N.
- Back-to-back terminal ticks with `reload` = 1 in auto mode give `borrow` high on consecutive cycles.

## Structure

- State encoding (2-bit: IDLE=0, RUN=1, PAUSED=2, EXPIRED=3) belongs in the shared project package, so display/debug logic can decode it.
- Single module with no sub-module. The decrement/reload datapath and the FSM are inline; the block is instantiated next to the existing up-counter.

## Test plan

- Reset with `DEFAULT_LOAD`=20 → `count`=20, `borrow`=0, `busy`=0, `load_ready`=1.
- Load 3, start, `auto_reload`=0, `tick` held high → `count` 3,2,1,0; `borrow` high one cycle coincident with `count`=0; state EXPIRED; `busy`=0.
- Load 2, `auto_reload`=1, tick every cycle for 6 cycles → `borrow` on the 2nd, 4th and 6th tick edges; `count` alternates 2,1.
- RUN at `count`=5: assert `stop` with `tick` → PAUSED with `count`=5. Ticks ignored; `start` resumes from 5. Then `stop` twice → IDLE with `count`=`reload`.
- `load_value`=0 in IDLE → `count`=1. Load attempt in RUN → `load_ready`=0 and `count` unaffected. `start`+`stop` together in IDLE → stays IDLE.
- `resetn` low in RUN at `count`=7 with `borrow` due → next cycle `count`=`DEFAULT_LOAD`, `borrow`=0, state IDLE.

Source files
------------

// File: rtl/generation_timer_pkg.sv
// rtl/generation_timer_pkg.sv - shared types for the generation timer
// State encoding is fixed so display/debug logic can decode the raw state bits.
package generation_timer_pkg;

  localparam int GT_STATE_W = 2;

  typedef enum logic [GT_STATE_W-1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } gt_state_e;

endpackage

// File: rtl/generation_timer.sv
// rtl/generation_timer.sv - loadable down-counter with borrow pulse and run/pause FSM
// Counts programmed ticks down, then pulses borrow to step the simulation one generation.
module generation_timer
  import generation_timer_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int DEFAULT_LOAD = 20
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             tick,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             stop,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             borrow,
  output logic             busy
);

  localparam logic [WIDTH-1:0] RESET_LOAD = WIDTH'(DEFAULT_LOAD);
  localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);

  gt_state_e        state_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] reload_q;
  logic             borrow_q;
  logic             busy_q;

  logic             load_acc;
  logic [WIDTH-1:0] load_d;

  assign load_ready = (state_q == ST_IDLE) || (state_q == ST_EXPIRED);
  assign load_acc   = load_valid && load_ready;
  // A zero reload would never reach the terminal count, so it is promoted to 1.
  assign load_d     = (load_value == '0) ? ONE : load_value;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      count_q  <= RESET_LOAD;
      reload_q <= RESET_LOAD;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      borrow_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_EXPIRED: begin
          if (load_acc) begin
            reload_q <= load_d;
            count_q  <= load_d;
          end
          if (start && !stop) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b1;
            count_q <= load_acc ? load_d : reload_q;
          end
        end
        ST_RUN: begin
          if (stop) begin
            state_q <= ST_PAUSED;
          end else if (tick) begin
            if (count_q == ONE) begin
              borrow_q <= 1'b1;
              if (auto_reload) begin
                count_q <= reload_q;
              end else begin
                count_q <= '0;
                state_q <= ST_EXPIRED;
                busy_q  <= 1'b0;
              end
            end else if (count_q > ONE) begin
              count_q <= count_q - ONE;
            end
          end
        end
        ST_PAUSED: begin
          if (stop) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            count_q <= reload_q;
          end else if (start) begin
            state_q <= ST_RUN;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign count  = count_q;
  assign borrow = borrow_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_generation_timer.sv
// tb/tb_generation_timer.sv - directed self-checking bench for generation_timer
module tb_generation_timer;
  import generation_timer_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         resetn, tick, load_valid, start, stop, auto_reload;
  logic         load_ready, borrow, busy;
  logic [W-1:0] load_value, count;

  int tests = 0;
  int fails = 0;

  generation_timer #(.WIDTH(W), .DEFAULT_LOAD(20)) dut (
    .clk(clk), .resetn(resetn), .tick(tick),
    .load_valid(load_valid), .load_ready(load_ready), .load_value(load_value),
    .start(start), .stop(stop), .auto_reload(auto_reload),
    .count(count), .borrow(borrow), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [W-1:0] v);
    load_valid = 1'b1; load_value = v;
    step();
    load_valid = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 0; tick = 0; load_valid = 0; load_value = '0;
    start = 0; stop = 0; auto_reload = 0;
    step(); step();
    resetn = 1;
    tests++; if (count !== 8'd20) begin fails++; $display("FAIL reset_count got %0d exp 20", count); end
    tests++; if (borrow !== 1'b0) begin fails++; $display("FAIL reset_borrow got %b exp 0", borrow); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
    tests++; if (load_ready !== 1'b1) begin fails++; $display("FAIL reset_load_ready got %b exp 1", load_ready); end
  endtask

  task automatic test_one_shot();
    logic [W-1:0] exp_c [3] = '{8'd2, 8'd1, 8'd0};
    do_load(8'd3);
    tests++; if (count !== 8'd3) begin fails++; $display("FAIL os_load got %0d exp 3", count); end
    start = 1; auto_reload = 0;
    step();
    start = 0;
    tests++; if (count !== 8'd3 || busy !== 1'b1) begin fails++; $display("FAIL os_start count %0d busy %b exp 3 1", count, busy); end
    tick = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if (count !== exp_c[i] || borrow !== (i == 2)) begin
        fails++; $display("FAIL os_tick%0d count %0d borrow %b exp %0d %b", i, count, borrow, exp_c[i], (i == 2));
      end
    end
    tests++; if (dut.state_q !== ST_EXPIRED || busy !== 1'b0) begin fails++; $display("FAIL os_expired state %0d busy %b exp 3 0", dut.state_q, busy); end
    step();
    tick = 0;
    tests++; if (borrow !== 1'b0 || count !== 8'd0) begin fails++; $display("FAIL os_after borrow %b count %0d exp 0 0", borrow, count); end
  endtask

  task automatic test_auto_reload();
    do_load(8'd2);
    start = 1;
    step();
    start = 0; auto_reload = 1; tick = 1;
    for (int i = 1; i <= 6; i++) begin
      step();
      tests++;
      if (count !== ((i % 2 == 0) ? 8'd2 : 8'd1) || borrow !== (i % 2 == 0)) begin
        fails++; $display("FAIL auto_tick%0d count %0d borrow %b exp %0d %b", i, count, borrow, (i % 2 == 0) ? 2 : 1, (i % 2 == 0));
      end
    end
    tick = 0; auto_reload = 0;
    stop = 1; step(); step(); stop = 0;
    tests++; if (dut.state_q !== ST_IDLE || count !== 8'd2) begin fails++; $display("FAIL auto_abort state %0d count %0d exp 0 2", dut.state_q, count); end
  endtask

  task automatic test_pause();
    do_load(8'd8);
    start = 1; step(); start = 0;
    tick = 1; step(); step(); step();
    stop = 1; step(); stop = 0;
    tests++; if (dut.state_q !== ST_PAUSED || count !== 8'd5 || busy !== 1'b1) begin fails++; $display("FAIL pause_enter state %0d count %0d busy %b exp 2 5 1", dut.state_q, count, busy); end
    step(); step();
    tests++; if (count !== 8'd5) begin fails++; $display("FAIL pause_ticks count %0d exp 5", count); end
    tick = 0; start = 1; step(); start = 0;
    tests++; if (dut.state_q !== ST_RUN || count !== 8'd5) begin fails++; $display("FAIL pause_resume state %0d count %0d exp 1 5", dut.state_q, count); end
    tick = 1; step(); tick = 0;
    tests++; if (count !== 8'd4) begin fails++; $display("FAIL pause_decr count %0d exp 4", count); end
    stop = 1; step();
    tests++; if (dut.state_q !== ST_PAUSED || count !== 8'd4) begin fails++; $display("FAIL pause_again state %0d count %0d exp 2 4", dut.state_q, count); end
    step(); stop = 0;
    tests++; if (dut.state_q !== ST_IDLE || count !== 8'd8 || busy !== 1'b0) begin fails++; $display("FAIL pause_abort state %0d count %0d busy %b exp 0 8 0", dut.state_q, count, busy); end
  endtask

  task automatic test_load_edges();
    do_load(8'd0);
    tests++; if (count !== 8'd1) begin fails++; $display("FAIL load_zero count %0d exp 1", count); end
    start = 1; step(); start = 0;
    load_valid = 1; load_value = 8'd9;
    #1;
    tests++; if (load_ready !== 1'b0) begin fails++; $display("FAIL load_ready_run got %b exp 0", load_ready); end
    step(); load_valid = 0;
    tests++; if (count !== 8'd1 || dut.reload_q !== 8'd1) begin fails++; $display("FAIL load_in_run count %0d reload %0d exp 1 1", count, dut.reload_q); end
    stop = 1; step(); step();
    start = 1; step(); start = 0; stop = 0;
    tests++; if (dut.state_q !== ST_IDLE || busy !== 1'b0) begin fails++; $display("FAIL start_stop_idle state %0d busy %b exp 0 0", dut.state_q, busy); end
    do_load(8'd4);
    load_valid = 1; load_value = 8'd6; start = 1;
    step(); load_valid = 0; start = 0;
    tests++; if (count !== 8'd6 || dut.state_q !== ST_RUN) begin fails++; $display("FAIL load_with_start count %0d state %0d exp 6 1", count, dut.state_q); end
    stop = 1; step(); step(); stop = 0;
  endtask

  task automatic test_back_to_back();
    do_load(8'd1);
    start = 1; step(); start = 0;
    auto_reload = 1; tick = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if (borrow !== 1'b1 || count !== 8'd1) begin fails++; $display("FAIL b2b_%0d borrow %b count %0d exp 1 1", i, borrow, count); end
    end
    resetn = 0; step(); resetn = 1;
    tick = 0; auto_reload = 0;
    tests++; if (borrow !== 1'b0 || count !== 8'd20 || dut.state_q !== ST_IDLE) begin fails++; $display("FAIL b2b_reset borrow %b count %0d state %0d exp 0 20 0", borrow, count, dut.state_q); end
  endtask

  task automatic test_reset_mid();
    do_load(8'd8);
    start = 1; step(); start = 0;
    tick = 1; step();
    tests++; if (count !== 8'd7) begin fails++; $display("FAIL mid_pre count %0d exp 7", count); end
    resetn = 0; step(); resetn = 1; tick = 0;
    tests++; if (count !== 8'd20 || borrow !== 1'b0 || dut.state_q !== ST_IDLE || busy !== 1'b0) begin
      fails++; $display("FAIL mid_reset count %0d borrow %b state %0d busy %b exp 20 0 0 0", count, borrow, dut.state_q, busy);
    end
    tests++; if (dut.reload_q !== 8'd20) begin fails++; $display("FAIL mid_reload got %0d exp 20", dut.reload_q); end
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_auto_reload();
    test_pause();
    test_load_edges();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
